// File: rtl/cndm_msi_pkg.sv
// Shared types and helpers for the PCIe MSI scheduler: FSM state encoding
// and the source-to-vector fold used when fewer vectors are allocated than sources.
package cndm_msi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        BACKOFF = 2'd3
    } msi_state_t;

    localparam int MSI_VEC_MAX = 32;

    // The host may grant up to 2^mmen vectors; anything beyond 32 is clamped.
    function automatic logic [4:0] msi_vec_map(input logic [4:0] idx, input logic [2:0] mmen);
        logic [2:0] m;
        logic [5:0] mask;
        m    = (mmen > 3'd5) ? 3'd5 : mmen;
        mask = (6'd1 << m) - 6'd1;
        return idx & mask[4:0];
    endfunction

endpackage

// File: rtl/cndm_msi_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Doubling the request vector turns the wrap into a plain lowest-set-bit search.
module cndm_msi_rr_pick #(
    parameter int IRQ_N = 32,
    parameter int IDX_W = 5
) (
    input  logic [IRQ_N-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [2*IRQ_N-1:0] dbl;
    logic [2*IRQ_N-1:0] masked;
    int                 pos;

    assign dbl   = {req, req};
    assign valid = |req;

    generate
        for (genvar gi = 0; gi < 2*IRQ_N; gi++) begin : g_mask
            assign masked[gi] = dbl[gi] & (gi >= int'(ptr));
        end
    endgenerate

    always_comb begin
        pos = 0;
        for (int i = 2*IRQ_N-1; i >= 0; i--) begin
            if (masked[i]) begin
                pos = i;
            end
        end
        idx = (pos >= IRQ_N) ? IDX_W'(pos - IRQ_N) : IDX_W'(pos);
    end

endmodule

// File: rtl/cndm_pcie_msi_sched.sv
// MSI scheduler for the UltraScale+ PCIe cfg_interrupt_msi_* port (PF0).
// Optional counters stat_sent/stat_fail/stat_timeout exist when CNDM_MSI_STATS_EN is defined.
module cndm_pcie_msi_sched
    import cndm_msi_pkg::*;
#(
    parameter int IRQ_N        = 32,
    parameter int RETRY_DELAY  = 64,
    parameter int WAIT_TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IRQ_N-1:0] irq_req,
    output logic [IRQ_N-1:0] irq_pending,
    output logic             busy,
    input  logic [3:0]       cfg_interrupt_msi_enable,
    input  logic [11:0]      cfg_interrupt_msi_mmenable,
    output logic [31:0]      cfg_interrupt_msi_int,
    input  logic             cfg_interrupt_msi_sent,
    input  logic             cfg_interrupt_msi_fail,
    output logic [1:0]       cfg_interrupt_msi_select,
    output logic [7:0]       cfg_interrupt_msi_function_number,
    output logic [2:0]       cfg_interrupt_msi_attr,
    output logic             cfg_interrupt_msi_tph_present,
    output logic [1:0]       cfg_interrupt_msi_tph_type,
    output logic [7:0]       cfg_interrupt_msi_tph_st_tag,
    output logic [31:0]      cfg_interrupt_msi_pending_status,
    output logic             cfg_interrupt_msi_pending_status_data_enable,
    output logic [1:0]       cfg_interrupt_msi_pending_status_function_num
`ifdef CNDM_MSI_STATS_EN
    ,
    output logic [31:0]      stat_sent,
    output logic [31:0]      stat_fail,
    output logic [31:0]      stat_timeout
`endif
);

    localparam int IDX_W = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;
    localparam int TMR_W = $clog2(WAIT_TIMEOUT);
    localparam int BO_W  = (RETRY_DELAY > 1) ? $clog2(RETRY_DELAY) : 1;

    msi_state_t       state_reg, state_next;
    logic [IRQ_N-1:0] pending_reg, pending_next;
    logic [IRQ_N-1:0] clr;
    logic [IRQ_N-1:0] sel_onehot;
    logic [IDX_W-1:0] rr_ptr_reg, sel_reg;
    logic [TMR_W-1:0] timer_reg;
    logic [BO_W-1:0]  backoff_reg;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             load_sel, done_sent, done_fail, done_timeout;
    logic             unused_cfg;

    assign unused_cfg = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

    cndm_msi_rr_pick #(
        .IRQ_N (IRQ_N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (pending_reg),
        .ptr   (rr_ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // A request arriving in the same cycle as its clear keeps the bit set.
    generate
        for (genvar gi = 0; gi < IRQ_N; gi++) begin : g_pend
            assign sel_onehot[gi]   = (sel_reg == IDX_W'(gi));
            assign pending_next[gi] = (pending_reg[gi] & ~clr[gi]) | irq_req[gi];
        end
    endgenerate

    always_comb begin
        state_next            = state_reg;
        clr                   = '0;
        load_sel              = 1'b0;
        done_sent             = 1'b0;
        done_fail             = 1'b0;
        done_timeout          = 1'b0;
        cfg_interrupt_msi_int = '0;
        case (state_reg)
            IDLE: begin
                if (cfg_interrupt_msi_enable[0] && pick_valid) begin
                    load_sel   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cfg_interrupt_msi_int = 32'd1 << msi_vec_map(5'(sel_reg), cfg_interrupt_msi_mmenable[2:0]);
                state_next            = WAIT;
            end
            WAIT: begin
                if (cfg_interrupt_msi_sent) begin
                    clr        = sel_onehot;
                    done_sent  = 1'b1;
                    state_next = IDLE;
                end else if (cfg_interrupt_msi_fail) begin
                    done_fail  = 1'b1;
                    state_next = BACKOFF;
                end else if (timer_reg == TMR_W'(WAIT_TIMEOUT-1)) begin
                    done_timeout = 1'b1;
                    state_next   = BACKOFF;
                end
            end
            BACKOFF: begin
                if (backoff_reg == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            rr_ptr_reg  <= '0;
            sel_reg     <= '0;
            timer_reg   <= '0;
            backoff_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            if (load_sel) begin
                sel_reg <= pick_idx;
            end
            if (done_sent) begin
                rr_ptr_reg <= (sel_reg == IDX_W'(IRQ_N-1)) ? '0 : sel_reg + IDX_W'(1);
            end
            if (state_reg == ISSUE) begin
                timer_reg <= '0;
            end else if (state_reg == WAIT) begin
                timer_reg <= timer_reg + TMR_W'(1);
            end
            // Loaded with N-1 so BACKOFF lasts exactly RETRY_DELAY cycles.
            if (done_fail || done_timeout) begin
                backoff_reg <= BO_W'(RETRY_DELAY-1);
            end else if (state_reg == BACKOFF && backoff_reg != '0) begin
                backoff_reg <= backoff_reg - BO_W'(1);
            end
        end
    end

`ifdef CNDM_MSI_STATS_EN
    logic [31:0] stat_sent_reg, stat_fail_reg, stat_timeout_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_sent_reg    <= '0;
            stat_fail_reg    <= '0;
            stat_timeout_reg <= '0;
        end else begin
            if (done_sent)    stat_sent_reg    <= stat_sent_reg + 32'd1;
            if (done_fail)    stat_fail_reg    <= stat_fail_reg + 32'd1;
            if (done_timeout) stat_timeout_reg <= stat_timeout_reg + 32'd1;
        end
    end

    assign stat_sent    = stat_sent_reg;
    assign stat_fail    = stat_fail_reg;
    assign stat_timeout = stat_timeout_reg;
`endif

    assign irq_pending = pending_reg;
    assign busy        = (state_reg != IDLE);

    assign cfg_interrupt_msi_select                      = '0;
    assign cfg_interrupt_msi_function_number             = '0;
    assign cfg_interrupt_msi_attr                        = '0;
    assign cfg_interrupt_msi_tph_present                 = 1'b0;
    assign cfg_interrupt_msi_tph_type                    = '0;
    assign cfg_interrupt_msi_tph_st_tag                  = '0;
    assign cfg_interrupt_msi_pending_status              = '0;
    assign cfg_interrupt_msi_pending_status_data_enable  = 1'b0;
    assign cfg_interrupt_msi_pending_status_function_num = '0;

endmodule
